// File: rtl/l2h_pkg.sv
// Shared constants and width helpers for the slow-to-fast capture block.
package l2h_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/l2h_sync_fifo.sv
// Show-ahead FIFO: head word visible on rdata whenever valid, pop on pop_req & valid.
module l2h_sync_fifo
  import l2h_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [DW-1:0]             wdata,
  input  logic                      pop_req,
  output logic [DW-1:0]             rdata,
  output logic                      valid,
  output logic                      drop,
  output logic [lvl_w(DEPTH)-1:0]   level
);

  localparam int PW = ptr_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          pop, full, push_ok;

  always_comb begin
    valid    = (level_q != '0);
    pop      = valid & pop_req;
    full     = (level_q == LW'(DEPTH));
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    push_ok  = push & (~full | pop);
    drop     = push & full & ~pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push_ok) level_d = level_q - 1'b1;
    rdata    = valid ? mem_q[rd_ptr_q] : '0;
  end

  // NOTE: the storage array has no reset; pointers and level are reset and rdata is gated by valid, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/l2h_sync_capture.sv
// Samples slow wclk in the rclk domain, detects the selected edge and captures din into a FIFO.
module l2h_sync_capture
  import l2h_pkg::*;
#(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0,
  parameter int DEPTH       = 4
) (
  input  logic                    rclk,
  input  logic                    rst,
  input  logic                    wclk,
  input  logic [DW-1:0]           din,
  input  logic                    en,
  output logic [DW-1:0]           dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    pe,
  output logic [lvl_w(DEPTH)-1:0] level,
  output logic                    overrun,
  input  logic                    ovr_clr
);

  localparam int AW = $clog2(SYNC_STAGES + 2);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [AW-1:0]          arm_q, arm_d;
  logic [DW-1:0]          din_q, din_d;
  logic                   pe_q, pe_d;
  logic                   ovr_q, ovr_d;
  logic                   s_last, armed, edge_det, push, fifo_drop;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], wclk};
    s_last   = sync_q[SYNC_STAGES-1];
    prev_d   = s_last;
    din_d    = din;
    armed    = (arm_q == AW'(SYNC_STAGES + 1));
    arm_d    = armed ? arm_q : arm_q + 1'b1;
    edge_det = s_last & ~prev_q;
    if (EDGE_MODE == EDGE_FALL)      edge_det = ~s_last & prev_q;
    else if (EDGE_MODE == EDGE_BOTH) edge_det = s_last ^ prev_q;
    // Edges seen while the chain is still filling after reset are ignored.
    push     = armed & edge_det & en;
    pe_d     = push;
    ovr_d    = ovr_q;
    if (fifo_drop)    ovr_d = 1'b1;
    else if (ovr_clr) ovr_d = 1'b0;
  end

  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      arm_q  <= '0;
      din_q  <= '0;
      pe_q   <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      arm_q  <= arm_d;
      din_q  <= din_d;
      pe_q   <= pe_d;
      ovr_q  <= ovr_d;
    end
  end

  l2h_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (rclk),
    .rst     (rst),
    .push    (push),
    .wdata   (din_q),
    .pop_req (dout_ready),
    .rdata   (dout),
    .valid   (dout_valid),
    .drop    (fifo_drop),
    .level   (level)
  );

  assign pe      = pe_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_l2h_sync_capture.sv
// Directed bench: a rising-edge DEPTH=4 instance and a both-edge DEPTH=8 instance share rclk/wclk/din.
module tb_l2h_sync_capture;

  logic       rclk, rst, wclk, en, ovr_clr;
  logic [7:0] din;
  logic       dout_ready, dout_ready2;
  logic [7:0] dout, dout2;
  logic       dout_valid, dout_valid2, pe, pe2, overrun, overrun2;
  logic [2:0] level;
  logic [3:0] level2;

  int n_tests = 0;
  int n_fail  = 0;
  int pe_cnt  = 0;
  int pe2_cnt = 0;
  int base, base2;

  l2h_sync_capture #(.DW(8), .SYNC_STAGES(2), .EDGE_MODE(0), .DEPTH(4)) u_dut (
    .rclk(rclk), .rst(rst), .wclk(wclk), .din(din), .en(en),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .pe(pe), .level(level), .overrun(overrun), .ovr_clr(ovr_clr)
  );

  l2h_sync_capture #(.DW(8), .SYNC_STAGES(2), .EDGE_MODE(2), .DEPTH(8)) u_dut_both (
    .rclk(rclk), .rst(rst), .wclk(wclk), .din(din), .en(en),
    .dout(dout2), .dout_valid(dout_valid2), .dout_ready(dout_ready2),
    .pe(pe2), .level(level2), .overrun(overrun2), .ovr_clr(ovr_clr)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  always @(negedge rclk) begin
    if (pe === 1'b1)  pe_cnt++;
    if (pe2 === 1'b1) pe2_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge rclk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Launch d on the falling wclk edge, then raise wclk; 10 rclk per wclk period.
  task automatic pulse(input logic [7:0] d);
    din  = d;
    wclk = 1'b0;
    tick(5);
    wclk = 1'b1;
    tick(5);
  endtask

  task automatic rise_checked(input logic [7:0] d);
    din  = d;
    wclk = 1'b0;
    tick(5);
    wclk = 1'b1;
    tick(1);
    tick(1);
    check("t1_pe_before_k2", pe, 0);
    check("t1_level_before_k2", level, 0);
    tick(1);
    check("t1_pe_at_k2", pe, 1);
    check("t1_valid_at_k2", dout_valid, 1);
    check("t1_dout_at_k2", dout, d);
    tick(1);
    check("t1_pe_after", pe, 0);
    check("t1_valid_after_pop", dout_valid, 0);
    tick(1);
  endtask

  initial begin
    rst = 1'b1; wclk = 1'b0; din = 8'h00; en = 1'b1; ovr_clr = 1'b0;
    dout_ready = 1'b1; dout_ready2 = 1'b0;
    tick(3);
    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_pe", pe, 0);
    check("rst_level", level, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    tick(5);

    // 1: basic capture, one pe per rise, write at k+2
    base = pe_cnt;
    rise_checked(8'h11);
    rise_checked(8'h22);
    rise_checked(8'h33);
    check("t1_pe_count", pe_cnt - base, 3);

    // 3: overrun and clear
    dout_ready = 1'b0;
    base = pe_cnt;
    for (int i = 1; i <= 6; i++) pulse(8'(i));
    check("t3_level_full", level, 4);
    check("t3_overrun_set", overrun, 1);
    check("t3_pe_count", pe_cnt - base, 6);
    check("t3_head", dout, 8'h01);
    ovr_clr = 1'b1;
    tick(1);
    ovr_clr = 1'b0;
    check("t3_overrun_clr", overrun, 0);
    dout_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("t3_drain_valid", dout_valid, 1);
      check("t3_drain_word", dout, 8'(i));
      tick(1);
    end
    check("t3_drained_valid", dout_valid, 0);
    check("t3_drained_level", level, 0);

    // 4: full with simultaneous pop in the strobe cycle
    dout_ready = 1'b0;
    pulse(8'hA1);
    pulse(8'hA2);
    pulse(8'hA3);
    pulse(8'hA4);
    check("t4_level_full", level, 4);
    din  = 8'hA5;
    wclk = 1'b0;
    tick(5);
    wclk = 1'b1;
    tick(2);
    dout_ready = 1'b1;
    tick(1);
    dout_ready = 1'b0;
    check("t4_level_stays", level, 4);
    check("t4_overrun_clear", overrun, 0);
    check("t4_pe", pe, 1);
    check("t4_head", dout, 8'hA2);
    tick(2);
    dout_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      check("t4_drain_word", dout, 8'hA0 + 8'(i));
      tick(1);
    end
    check("t4_drained_level", level, 0);

    // 2: both-edge instance, 8 edges at 5 MHz
    rst  = 1'b1;
    wclk = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(5);
    base2 = pe2_cnt;
    for (int i = 0; i < 8; i++) begin
      din = 8'h50 + 8'(i);
      tick(5);
      wclk = ~wclk;
      tick(5);
    end
    tick(5);
    check("t2_level", level2, 8);
    check("t2_overrun", overrun2, 0);
    check("t2_pe_count", pe2_cnt - base2, 8);
    dout_ready2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t2_drain_word", dout2, 8'h50 + 8'(i));
      tick(1);
    end
    check("t2_drained_valid", dout_valid2, 0);
    dout_ready2 = 1'b0;

    // 5: arming with wclk high through reset release
    wclk = 1'b1;
    rst  = 1'b1;
    tick(2);
    rst   = 1'b0;
    base  = pe_cnt;
    base2 = pe2_cnt;
    tick(20);
    check("t5_no_pe", pe_cnt - base, 0);
    check("t5_level", level, 0);
    check("t5_no_pe2", pe2_cnt - base2, 0);
    check("t5_level2", level2, 0);
    dout_ready = 1'b0;
    pulse(8'hC5);
    check("t5_capture_level", level, 1);
    check("t5_capture_word", dout, 8'hC5);
    check("t5_capture_pe", pe_cnt - base, 1);
    check("t5_both_level2", level2, 2);
    check("t5_both_word", dout2, 8'hC5);

    // 6: enable low, then mid-operation reset
    base = pe_cnt;
    en   = 1'b0;
    pulse(8'hE1);
    pulse(8'hE2);
    pulse(8'hE3);
    en = 1'b1;
    check("t6_en_no_pe", pe_cnt - base, 0);
    check("t6_en_level", level, 1);
    check("t6_en_level2", level2, 2);
    check("t6_en_head", dout, 8'hC5);
    pulse(8'hD2);
    check("t6_level_two", level, 2);
    rst = 1'b1;
    #1;
    check("t6_async_valid", dout_valid, 0);
    check("t6_async_level", level, 0);
    check("t6_async_dout", dout, 0);
    tick(2);
    rst = 1'b0;
    tick(3);
    check("t6_post_level", level, 0);
    check("t6_post_valid", dout_valid, 0);
    check("t6_post_pe", pe, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
